microwave_timer: RTL and testbench
==================================

Name: microwave_timer

Overview:
Countdown cooking timer that sits at the far end of the magnetron interface. It consumes mag_on from the magnetron controller and produces timer_done, which resets the magnetron latch. Keypad digits load a 4-digit BCD mm:ss value. The value counts down one second per prescaled tick while mag_on is high.

Parameters:
TICKS_PER_SEC, 50_000_000, clk cycles per second; minimum 2.
PRESC_W, 26, prescaler width; must satisfy 2^PRESC_W >= TICKS_PER_SEC.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
mag_on  input  1  magnetron running; the countdown runs only while this is high
clearn  input  1  active-low synchronous clear of time and done
digit_valid  input  1  one-cycle strobe; digit is valid
digit  input  4  keypad BCD digit 0-9
min_tens  output  4  BCD minutes tens
min_ones  output  4  BCD minutes ones
sec_tens  output  4  BCD seconds tens
sec_ones  output  4  BCD seconds ones
running  output  1  high in state RUN
timer_done  output  1  registered level; time expired or zero-time start

Behaviour:
- rst (async): all digits 0, prescaler 0, timer_done 0, state IDLE.
- States:
  - IDLE: value 0000, not done.
  - SET: value nonzero, mag_on low.
  - RUN: mag_on high, value nonzero.
  - DONE: timer_done high.
- Priority on each edge: rst > clearn low > digit entry > countdown tick.
- clearn low: digits 0, prescaler 0, timer_done 0, state IDLE. This applies in any state, including RUN.
- Digit entry:
  - Accepted only when digit_valid=1, digit<=9 and mag_on=0. Otherwise ignored with no state change.
  - Shift-left: min_tens<=min_ones, min_ones<=sec_tens, sec_tens<=sec_ones, sec_ones<=digit.
  - Prescaler is cleared.
  - In DONE: timer_done clears and the shift proceeds from the current 0000.
  - Next state is SET if the result is nonzero, else IDLE.
- sec_tens may exceed 5 after entry (e.g. 00:90). This is legal and counts down as 90 seconds.
- Prescaler:
  - Increments only while mag_on=1 and the value is nonzero.
  - Holds while mag_on=0, so a pause keeps the partial second.
  - Wraps at TICKS_PER_SEC-1; the wrap cycle is the tick.
- Countdown tick, BCD decrement with borrow:
  - sec_ones=0 borrows from sec_tens, giving x9.
  - sec=00 borrows from minutes, and seconds become 59.
  - min_ones=0 borrows from min_tens.
- Expiry: the tick that moves 00:01 to 00:00 sets timer_done on the same edge. State becomes DONE and the prescaler clears.
- Zero-time start: mag_on=1 with value 0000 and not done sets timer_done on the next edge (state DONE). This guarantees the magnetron is stopped within one cycle.
- DONE:
  - timer_done holds until clearn or an accepted digit.
  - The prescaler is frozen and mag_on is ignored.
- RUN->SET when mag_on falls while the value is nonzero. SET->RUN when mag_on rises.
- running = (state==RUN), registered.
- The maximum value is 99:99. No overflow is possible by entry, because the fifth digit shifts out the oldest one.

Optional Feature:
Macro TIMER_ADD30_EN.
- When defined, adds input add30n (active-low button). It is registered and falling-edge detected inside the block.
- Each detected press adds 30 s in BCD with carry, saturating at 99:99. It is allowed in any state, including RUN, and the prescaler is untouched.
- In DONE, a press clears timer_done and loads 00:30. The state becomes SET, or RUN if mag_on is high.
- clearn and digit entry take priority over a same-cycle press.
- When not defined, there is no port, no logic, and behaviour is exactly as above.

Decomposition:
Shared package microwave_pkg holds:
- state encoding (IDLE, SET, RUN, DONE);
- the 4-bit BCD digit type;
- constants BCD_NINE=4'd9 and BCD_FIVE=4'd5;
- the default TICKS_PER_SEC.

One sub-module, bcd_down_counter4. It implements the 4-digit decrement with borrow, plus the load/shift and clear ports. The FSM and prescaler stay in microwave_timer.

Test Plan:
1. rst, then digits 1,2,3 strobed with mag_on=0 -> outputs 01:23, running=0, timer_done=0. Digit 4'hA is then ignored.
2. TICKS_PER_SEC=4, load 00:03, raise mag_on -> 00:02, 00:01 and 00:00 at 4-cycle intervals. timer_done rises on the edge reaching 00:00 (cycle 12); running=0.
3. Load 01:00, mag_on for one tick -> 00:59. Load 10:00, one tick -> 09:59.
4. 00:05 running, drop mag_on after 2 cycles for 10 cycles, then raise it -> value holds at 00:05 and the next decrement occurs 2 cycles after the rise.
5. clearn low mid-RUN at 00:42 -> 00:00, timer_done=0, IDLE. mag_on=1 with 00:00 -> timer_done=1 on the next edge. A digit strobe then clears it.
6. (TIMER_ADD30_EN) add30n press at 99:50 -> 99:99. A press in DONE -> 00:30, timer_done=0.

Source files
------------

// File: rtl/microwave_pkg.sv
// Shared types and constants for the microwave countdown timer.
// Holds the FSM encoding, the BCD digit/time types and the +30 s helper.
package microwave_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SET,
    ST_RUN,
    ST_DONE
  } state_t;

  typedef logic [3:0] bcd_t;

  typedef struct packed {
    bcd_t mt;
    bcd_t mo;
    bcd_t st;
    bcd_t so;
  } mmss_t;

  localparam bcd_t BCD_NINE = 4'd9;
  localparam bcd_t BCD_FIVE = 4'd5;
  localparam int DEF_TICKS_PER_SEC = 50_000_000;

  // Adds 30 s; sec_tens may be above 5, so carry once tens reach 6+.
  function automatic mmss_t bcd_add30(input mmss_t v);
    mmss_t r;
    logic [4:0] t;
    r = v;
    t = {1'b0, v.st} + 5'd3;
    if (t >= 5'd6) begin
      r.st = 4'(t - 5'd6);
      if (v.mo != BCD_NINE) begin
        r.mo = v.mo + 4'd1;
      end else if (v.mt != BCD_NINE) begin
        r.mo = 4'd0;
        r.mt = v.mt + 4'd1;
      end else begin
        r = {BCD_NINE, BCD_NINE, BCD_NINE, BCD_NINE};
      end
    end else begin
      r.st = t[3:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/microwave_timer_if.sv
// Keypad/magnetron side bundle of the microwave timer.
// add30n exists only when TIMER_ADD30_EN is defined.
interface microwave_timer_if
  import microwave_pkg::*;
  ;
  logic mag_on;
  logic clearn;
  logic digit_valid;
  bcd_t digit;
  bcd_t min_tens;
  bcd_t min_ones;
  bcd_t sec_tens;
  bcd_t sec_ones;
  logic running;
  logic timer_done;
`ifdef TIMER_ADD30_EN
  logic add30n;

  modport master (
    output mag_on, clearn, digit_valid, digit, add30n,
    input  min_tens, min_ones, sec_tens, sec_ones,
    input  running, timer_done
  );

  modport slave (
    input  mag_on, clearn, digit_valid, digit, add30n,
    output min_tens, min_ones, sec_tens, sec_ones,
    output running, timer_done
  );
`else
  modport master (
    output mag_on, clearn, digit_valid, digit,
    input  min_tens, min_ones, sec_tens, sec_ones,
    input  running, timer_done
  );

  modport slave (
    input  mag_on, clearn, digit_valid, digit,
    output min_tens, min_ones, sec_tens, sec_ones,
    output running, timer_done
  );
`endif
endinterface

// File: rtl/bcd_down_counter4.sv
// Four-digit mm:ss BCD register with clear, load, shift-in and
// decrement-with-borrow; priority clr > load > shift > dec.
module bcd_down_counter4
  import microwave_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  clr,
  input  logic  load,
  input  logic  shift,
  input  logic  dec,
  input  mmss_t load_val,
  input  bcd_t  shift_in,
  output mmss_t value,
  output logic  zero
);

  mmss_t dec_val;

  always_comb begin
    dec_val = value;
    if (value.so != 4'd0) begin
      dec_val.so = value.so - 4'd1;
    end else begin
      dec_val.so = BCD_NINE;
      if (value.st != 4'd0) begin
        dec_val.st = value.st - 4'd1;
      end else begin
        dec_val.st = BCD_FIVE;
        if (value.mo != 4'd0) begin
          dec_val.mo = value.mo - 4'd1;
        end else begin
          dec_val.mo = BCD_NINE;
          dec_val.mt = value.mt - 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= '0;
    end else if (clr) begin
      value <= '0;
    end else if (load) begin
      value <= load_val;
    end else if (shift) begin
      value <= {value.mo, value.st, value.so, shift_in};
    end else if (dec) begin
      value <= dec_val;
    end
  end

  assign zero = (value == '0);

endmodule

// File: rtl/microwave_timer.sv
// Microwave countdown timer: keypad mm:ss entry, per-second countdown
// while mag_on is high. Optional +30 s button under TIMER_ADD30_EN.
module microwave_timer
  import microwave_pkg::*;
#(
  parameter int TICKS_PER_SEC = DEF_TICKS_PER_SEC,
  parameter int PRESC_W       = 26
) (
  input logic             clk,
  input logic             rst,
  microwave_timer_if.slave bus
);

  localparam logic [PRESC_W-1:0] PRESC_MAX =
    PRESC_W'(TICKS_PER_SEC - 1);

  state_t state_q, state_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic done_q, done_d;

  logic  cnt_clr, cnt_load, cnt_shift, cnt_dec;
  mmss_t load_val;
  mmss_t cur;
  logic  zero;
  logic  dig_acc;
  logic  is_one;
  logic  shift_nz;

  bcd_down_counter4 u_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (cnt_clr),
    .load     (cnt_load),
    .shift    (cnt_shift),
    .dec      (cnt_dec),
    .load_val (load_val),
    .shift_in (bus.digit),
    .value    (cur),
    .zero     (zero)
  );

`ifdef TIMER_ADD30_EN
  logic add_q1, add_q2, press;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      add_q1 <= 1'b1;
      add_q2 <= 1'b1;
    end else begin
      add_q1 <= bus.add30n;
      add_q2 <= add_q1;
    end
  end

  assign press = add_q2 & ~add_q1;
`endif

  assign dig_acc = bus.digit_valid
                 && (bus.digit <= BCD_NINE)
                 && !bus.mag_on;
  assign is_one   = (cur == 16'h0001);
  assign shift_nz = ({cur.mo, cur.st, cur.so, bus.digit} != 16'h0);

  always_comb begin
    state_d   = state_q;
    presc_d   = presc_q;
    done_d    = done_q;
    cnt_clr   = 1'b0;
    cnt_load  = 1'b0;
    cnt_shift = 1'b0;
    cnt_dec   = 1'b0;
    load_val  = cur;
    if (!bus.clearn) begin
      cnt_clr = 1'b1;
      presc_d = '0;
      done_d  = 1'b0;
      state_d = ST_IDLE;
    end else if (dig_acc) begin
      cnt_shift = 1'b1;
      presc_d   = '0;
      done_d    = 1'b0;
      state_d   = shift_nz ? ST_SET : ST_IDLE;
`ifdef TIMER_ADD30_EN
    end else if (press) begin
      cnt_load = 1'b1;
      done_d   = 1'b0;
      state_d  = bus.mag_on ? ST_RUN : ST_SET;
      load_val = done_q ? mmss_t'(16'h0030) : bcd_add30(cur);
`endif
    end else if (done_q) begin
      state_d = ST_DONE;
    end else if (bus.mag_on) begin
      if (zero) begin
        done_d  = 1'b1;
        state_d = ST_DONE;
      end else if (presc_q == PRESC_MAX) begin
        presc_d = '0;
        cnt_dec = 1'b1;
        // The tick that lands on 00:00 ends the cook on this edge
        if (is_one) begin
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          state_d = ST_RUN;
        end
      end else begin
        presc_d = presc_q + PRESC_W'(1);
        state_d = ST_RUN;
      end
    end else begin
      state_d = zero ? ST_IDLE : ST_SET;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      presc_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      done_q  <= done_d;
    end
  end

  assign bus.min_tens   = cur.mt;
  assign bus.min_ones   = cur.mo;
  assign bus.sec_tens   = cur.st;
  assign bus.sec_ones   = cur.so;
  assign bus.running    = (state_q == ST_RUN);
  assign bus.timer_done = done_q;

endmodule

// File: tb/tb_microwave_timer.sv
// Directed bench for microwave_timer with TICKS_PER_SEC=4.
// Table vectors plus hand sequences for countdown, pause and clear.
module tb_microwave_timer;
  import microwave_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  microwave_timer_if bus ();

  microwave_timer #(
    .TICKS_PER_SEC (4),
    .PRESC_W       (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [15:0] val;
  assign val = {bus.min_tens, bus.min_ones, bus.sec_tens, bus.sec_ones};

  typedef struct {
    logic        dv;
    logic [3:0]  d;
    logic        mag;
    logic        clr;
    logic [15:0] ev;
    logic        er;
    logic        ed;
  } vec_t;

  vec_t tv[10];

  task automatic cyc(input logic dv, input logic [3:0] d,
                     input logic mag, input logic clr);
    bus.digit_valid = dv;
    bus.digit       = d;
    bus.mag_on      = mag;
    bus.clearn      = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [15:0] ev,
                     input logic er, input logic ed);
    total++;
    if ({val, bus.running, bus.timer_done} !== {ev, er, ed}) begin
      bad++;
      $display("FAIL %s: got %h run=%b done=%b, want %h run=%b done=%b",
               nm, val, bus.running, bus.timer_done, ev, er, ed);
    end
  endtask

  task automatic key(input logic [3:0] d);
    cyc(1'b1, d, 1'b0, 1'b1);
  endtask

  task automatic clear();
    cyc(1'b0, 4'd0, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tv[0] = '{1'b1, 4'd1,  1'b0, 1'b1, 16'h0001, 1'b0, 1'b0};
    tv[1] = '{1'b1, 4'd2,  1'b0, 1'b1, 16'h0012, 1'b0, 1'b0};
    tv[2] = '{1'b1, 4'd3,  1'b0, 1'b1, 16'h0123, 1'b0, 1'b0};
    tv[3] = '{1'b1, 4'hA,  1'b0, 1'b1, 16'h0123, 1'b0, 1'b0};
    tv[4] = '{1'b0, 4'd7,  1'b0, 1'b1, 16'h0123, 1'b0, 1'b0};
    tv[5] = '{1'b1, 4'd5,  1'b1, 1'b1, 16'h0123, 1'b1, 1'b0};
    tv[6] = '{1'b0, 4'd0,  1'b0, 1'b1, 16'h0123, 1'b0, 1'b0};
    tv[7] = '{1'b1, 4'd4,  1'b1, 1'b0, 16'h0000, 1'b0, 1'b0};
    tv[8] = '{1'b1, 4'd9,  1'b0, 1'b1, 16'h0009, 1'b0, 1'b0};
    tv[9] = '{1'b1, 4'd0,  1'b0, 1'b1, 16'h0090, 1'b0, 1'b0};

    bus.digit_valid = 1'b0;
    bus.digit       = 4'd0;
    bus.mag_on      = 1'b0;
    bus.clearn      = 1'b1;
`ifdef TIMER_ADD30_EN
    bus.add30n      = 1'b1;
`endif
    rst = 1'b1;
    #12;
    chk("reset", 16'h0000, 1'b0, 1'b0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 10; i++) begin
      cyc(tv[i].dv, tv[i].d, tv[i].mag, tv[i].clr);
      chk($sformatf("vec%0d", i), tv[i].ev, tv[i].er, tv[i].ed);
    end

    // Countdown 00:03 -> 00:00 in 4-cycle seconds
    clear();
    key(4'd3);
    chk("load3", 16'h0003, 1'b0, 1'b0);
    for (int k = 1; k <= 12; k++) begin
      cyc(1'b0, 4'd0, 1'b1, 1'b1);
      chk($sformatf("cnt%0d", k), {12'h000, 4'(3 - k / 4)},
          (k < 12), (k == 12));
    end
    cyc(1'b0, 4'd0, 1'b1, 1'b1);
    chk("done_hold", 16'h0000, 1'b0, 1'b1);
    cyc(1'b1, 4'd6, 1'b1, 1'b1);
    chk("done_dig_magon", 16'h0000, 1'b0, 1'b1);
    clear();
    chk("clr_done", 16'h0000, 1'b0, 1'b0);

    // Borrow across seconds and minutes
    key(4'd1); key(4'd0); key(4'd0);
    chk("load0100", 16'h0100, 1'b0, 1'b0);
    repeat (4) cyc(1'b0, 4'd0, 1'b1, 1'b1);
    chk("borrow0059", 16'h0059, 1'b1, 1'b0);
    clear();
    key(4'd1); key(4'd0); key(4'd0); key(4'd0);
    chk("load1000", 16'h1000, 1'b0, 1'b0);
    repeat (4) cyc(1'b0, 4'd0, 1'b1, 1'b1);
    chk("borrow0959", 16'h0959, 1'b1, 1'b0);
    clear();

    // Pause keeps the partial second
    key(4'd5);
    repeat (2) cyc(1'b0, 4'd0, 1'b1, 1'b1);
    chk("pre_pause", 16'h0005, 1'b1, 1'b0);
    repeat (10) cyc(1'b0, 4'd0, 1'b0, 1'b1);
    chk("paused", 16'h0005, 1'b0, 1'b0);
    cyc(1'b0, 4'd0, 1'b1, 1'b1);
    chk("resume1", 16'h0005, 1'b1, 1'b0);
    cyc(1'b0, 4'd0, 1'b1, 1'b1);
    chk("resume2", 16'h0004, 1'b1, 1'b0);
    clear();

    // Clear mid-run, then zero-time start, then digit clears done
    key(4'd4); key(4'd2);
    repeat (2) cyc(1'b0, 4'd0, 1'b1, 1'b1);
    chk("run42", 16'h0042, 1'b1, 1'b0);
    cyc(1'b0, 4'd0, 1'b1, 1'b0);
    chk("clr_run", 16'h0000, 1'b0, 1'b0);
    cyc(1'b0, 4'd0, 1'b1, 1'b1);
    chk("zero_start", 16'h0000, 1'b0, 1'b1);
    cyc(1'b0, 4'd0, 1'b0, 1'b1);
    chk("zero_hold", 16'h0000, 1'b0, 1'b1);
    key(4'd7);
    chk("dig_clr_done", 16'h0007, 1'b0, 1'b0);

    // Fifth digit shifts the oldest one out
    key(4'd9); key(4'd9); key(4'd9); key(4'd1);
    chk("shift_out", 16'h9991, 1'b0, 1'b0);

`ifdef TIMER_ADD30_EN
    clear();
    key(4'd9); key(4'd9); key(4'd5); key(4'd0);
    bus.add30n = 1'b0;
    repeat (3) cyc(1'b0, 4'd0, 1'b0, 1'b1);
    bus.add30n = 1'b1;
    chk("add30_sat", 16'h9999, 1'b0, 1'b0);
    repeat (2) cyc(1'b0, 4'd0, 1'b0, 1'b1);
    chk("add30_once", 16'h9999, 1'b0, 1'b0);
    clear();
    cyc(1'b0, 4'd0, 1'b1, 1'b1);
    cyc(1'b0, 4'd0, 1'b0, 1'b1);
    chk("pre_add_done", 16'h0000, 1'b0, 1'b1);
    bus.add30n = 1'b0;
    repeat (3) cyc(1'b0, 4'd0, 1'b0, 1'b1);
    bus.add30n = 1'b1;
    chk("add30_done", 16'h0030, 1'b0, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
